// File: rtl/amt_recovery_ctrl_if.sv
// AMT recovery handshake bundle: request/idle from the ActiveList side,
// walk, block, stall and done indications back from the controller.
interface amt_recovery_ctrl_if #(
  parameter int SIZE_RMT_LOG = 5
);
  logic                    recoverReq_i;
  logic                    commitIdle_i;
  logic                    recoverFlag_o;
  logic [SIZE_RMT_LOG-1:0] recoverCnt_o;
  logic [3:0]              rmtWe_o;
  logic                    commitBlock_o;
  logic                    renameStall_o;
  logic                    recoverDone_o;
  logic                    recoverOverlap_o;

  modport master (
    output recoverReq_i,
    output commitIdle_i,
    input  recoverFlag_o,
    input  recoverCnt_o,
    input  rmtWe_o,
    input  commitBlock_o,
    input  renameStall_o,
    input  recoverDone_o,
    input  recoverOverlap_o
  );

  modport slave (
    input  recoverReq_i,
    input  commitIdle_i,
    output recoverFlag_o,
    output recoverCnt_o,
    output rmtWe_o,
    output commitBlock_o,
    output renameStall_o,
    output recoverDone_o,
    output recoverOverlap_o
  );
endinterface

// File: rtl/amt_recovery_ctrl.sv
// AMT recovery sequencer: drain commit, walk the AMT 4 entries per cycle
// into the RMT, then pulse done. Ports: clk, reset, rec (slave modport).
module amt_recovery_ctrl #(
  parameter int SIZE_RMT      = 32,
  parameter int SIZE_RMT_LOG  = 5,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  amt_recovery_ctrl_if.slave rec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_WALK,
    S_DONE
  } state_e;

  localparam logic [SIZE_RMT_LOG-1:0] LAST =
    SIZE_RMT_LOG'(SIZE_RMT - 4);
  localparam logic [SIZE_RMT_LOG-1:0] STEP =
    SIZE_RMT_LOG'(4);
  localparam logic [3:0] DRAIN_TO =
    4'(DRAIN_TIMEOUT);

  state_e                  state_q, state_d;
  logic [SIZE_RMT_LOG-1:0] cnt_q, cnt_d;
  logic [3:0]              drain_q, drain_d;
  logic                    ovl_q, ovl_d;
  logic [3:0]              drain_inc;

  assign drain_inc = drain_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      ovl_q   <= ovl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    ovl_d   = ovl_q;
    unique case (state_q)
      S_IDLE: begin
        if (rec.recoverReq_i) begin
          state_d = S_DRAIN;
          drain_d = '0;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (rec.commitIdle_i) begin
          state_d = S_WALK;
        end else begin
          drain_d = drain_inc;
          if (drain_inc == DRAIN_TO) state_d = S_WALK;
        end
      end
      S_WALK: begin
        // Explicit wrap: SIZE_RMT need not be a power of two.
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A request while busy is dropped; only flag it.
    if (rec.recoverReq_i && (state_q != S_IDLE)) ovl_d = 1'b1;
  end

  logic       flag, block, stall, done;
  logic [3:0] we;

  always_comb begin
    flag  = 1'b0;
    we    = 4'b0000;
    block = 1'b0;
    stall = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_DRAIN: begin
        block = 1'b1;
        stall = 1'b1;
      end
      S_WALK: begin
        flag  = 1'b1;
        we    = 4'b1111;
        block = 1'b1;
        stall = 1'b1;
      end
      S_DONE: begin
        stall = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign rec.recoverFlag_o    = flag;
  assign rec.recoverCnt_o     = cnt_q;
  assign rec.rmtWe_o          = we;
  assign rec.commitBlock_o    = block;
  assign rec.renameStall_o    = stall;
  assign rec.recoverDone_o    = done;
  assign rec.recoverOverlap_o = ovl_q;

endmodule

// File: tb/tb_amt_recovery_ctrl.sv
// Directed plus random bench for amt_recovery_ctrl against a
// cycle-level reference model of the recovery sequence.
module tb_amt_recovery_ctrl;

  localparam int N_GRP = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  amt_recovery_ctrl_if #(.SIZE_RMT_LOG(5)) bus ();

  amt_recovery_ctrl #(
    .SIZE_RMT(32),
    .SIZE_RMT_LOG(5),
    .DRAIN_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rec(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 draining, 2 walking, 3 done.
  int m_phase = 0;
  int m_drain = 0;
  int m_group = 0;
  bit m_ovl   = 1'b0;

  int drain_seen = 0;
  int walk_seen  = 0;
  int done_seen  = 0;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rq, input bit ci, input bit rs);
    if (rs) begin
      m_phase = 0; m_drain = 0; m_group = 0; m_ovl = 1'b0;
    end else begin
      if (rq && m_phase != 0) m_ovl = 1'b1;
      case (m_phase)
        0: if (rq) begin
          m_phase = 1; m_drain = 0; m_group = 0;
        end
        1: if (ci) m_phase = 2;
           else begin
             m_drain++;
             if (m_drain == 15) m_phase = 2;
           end
        2: if (m_group == N_GRP - 1) begin
             m_phase = 3; m_group = 0;
           end else m_group++;
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [15:0] e, o;
    e = '0;
    e[8]   = (m_phase == 2);
    e[7:4] = (m_phase == 2) ? 4'hF : 4'h0;
    e[3]   = (m_phase == 1) || (m_phase == 2);
    e[2]   = (m_phase != 0);
    e[1]   = (m_phase == 3);
    e[0]   = m_ovl;
    o = '0;
    o[8]   = bus.recoverFlag_o;
    o[7:4] = bus.rmtWe_o;
    o[3]   = bus.commitBlock_o;
    o[2]   = bus.renameStall_o;
    o[1]   = bus.recoverDone_o;
    o[0]   = bus.recoverOverlap_o;
    check("ctl", o, e);
    check("cnt", 16'(bus.recoverCnt_o), 16'(4 * m_group));
    if (bus.commitBlock_o && !bus.recoverFlag_o) drain_seen++;
    if (bus.recoverFlag_o) walk_seen++;
    if (bus.recoverDone_o) done_seen++;
  endtask

  task automatic cyc(input bit rq, input bit ci, input bit rs);
    bus.recoverReq_i = rq;
    bus.commitIdle_i = ci;
    reset = rs;
    @(posedge clk);
    model_edge(rq, ci, rs);
    #1;
    compare_all();
  endtask

  task automatic clr_seen();
    drain_seen = 0; walk_seen = 0; done_seen = 0;
  endtask

  // idle_after: commitIdle stays low this many cycles after the request.
  task automatic run_recovery(input int idle_after);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 60 && m_phase != 0; i++)
      cyc(1'b0, (i >= idle_after), 1'b0);
    check("finish_bound", 16'(m_phase), 16'd0);
  endtask

  initial begin
    bus.recoverReq_i = 1'b0;
    bus.commitIdle_i = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("rst_flag", 16'(bus.recoverFlag_o), 16'd0);
    cyc(1'b0, 1'b1, 1'b0);

    clr_seen();
    run_recovery(0);
    check("t1_drain", 16'(drain_seen), 16'd1);
    check("t1_walk", 16'(walk_seen), 16'd8);
    check("t1_done", 16'(done_seen), 16'd1);

    clr_seen();
    run_recovery(3);
    check("t2_drain", 16'(drain_seen), 16'd4);
    check("t2_walk", 16'(walk_seen), 16'd8);

    clr_seen();
    run_recovery(1000);
    check("t3_drain", 16'(drain_seen), 16'd15);
    check("t3_walk", 16'(walk_seen), 16'd8);
    check("t3_done", 16'(done_seen), 16'd1);

    clr_seen();
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !(m_phase == 2 && m_group == 3); i++)
      cyc(1'b0, 1'b1, 1'b0);
    check("t4_at12", 16'(bus.recoverCnt_o), 16'd12);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_phase != 0; i++)
      cyc(1'b0, 1'b1, 1'b0);
    check("t4_walk", 16'(walk_seen), 16'd8);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    check("t4_ovl", 16'(bus.recoverOverlap_o), 16'd1);

    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !(m_phase == 2 && m_group == 4); i++)
      cyc(1'b0, 1'b1, 1'b0);
    check("t5_at16", 16'(bus.recoverCnt_o), 16'd16);
    cyc(1'b0, 1'b1, 1'b1);
    check("t5_we", 16'(bus.rmtWe_o), 16'd0);
    check("t5_ovl", 16'(bus.recoverOverlap_o), 16'd0);
    cyc(1'b0, 1'b1, 1'b0);
    clr_seen();
    run_recovery(0);
    check("t5_walk", 16'(walk_seen), 16'd8);

    clr_seen();
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_phase != 3; i++)
      cyc(1'b0, 1'b1, 1'b0);
    check("t6_done", 16'(bus.recoverDone_o), 16'd1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_phase != 0; i++)
      cyc(1'b0, 1'b1, 1'b0);
    check("t6_walk", 16'(walk_seen), 16'd16);
    check("t6_ovl", 16'(bus.recoverOverlap_o), 16'd0);

    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 99) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
